// File: rtl/ddr2_cmd_responder.sv
// rtl/ddr2_cmd_responder.sv - DDR2 command responder: init FSM, bank tracking and burst memory model
module ddr2_cmd_responder #(
  parameter int BA_BITS      = 3,
  parameter int ADDR_BITS    = 13,
  parameter int DQ_BITS      = 16,
  parameter int DM_BITS      = 2,
  parameter int COL_IDX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DQ_BITS-1:0]   dq_in,
  input  logic [DM_BITS-1:0]   dm,
  output logic [DQ_BITS-1:0]   dq_out,
  output logic                 dq_oe,
  output logic                 ready,
  output logic                 err,
  output logic [2:0]           err_code
);
  localparam int NBANK  = 1 << BA_BITS;
  localparam int MEM_AW = BA_BITS + COL_IDX_BITS;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int BYTE_W = DQ_BITS / DM_BITS;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  localparam logic [2:0] E_NOT_INIT = 3'd1, E_BAD_MODE = 3'd2, E_ACT_OPEN = 3'd3;
  localparam logic [2:0] E_REF_OPEN = 3'd4, E_CLOSED   = 3'd5, E_OVERLAP  = 3'd6;

  typedef enum logic [1:0] {PWRUP, WAIT_PREA, WAIT_MRS, READY} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [2:0]              cl_q, cl_d;
  logic                    bl8_q, bl8_d;
  logic [NBANK-1:0]        open_q, open_d;
  logic [ADDR_BITS-1:0]    row_q [NBANK];
  logic [ADDR_BITS-1:0]    row_d [NBANK];
  logic                    busy_q, busy_d;
  logic                    rd_q, rd_d;
  logic                    bbl8_q, bbl8_d;
  logic [2:0]              wait_q, wait_d;
  logic [2:0]              beat_q, beat_d;
  logic [BA_BITS-1:0]      bank_q, bank_d;
  logic [COL_IDX_BITS-1:0] start_q, start_d;
  logic                    err_q, err_d;
  logic [2:0]              code_q, code_d;
  logic                    dq_oe_q, dq_oe_d;
  logic [DQ_BITS-1:0]      dq_out_q, dq_out_d;

  logic [DQ_BITS-1:0]      mem_q [DEPTH];
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_idx;
  logic [DQ_BITS-1:0]      mem_wdata;

  logic [2:0]              cmd;
  logic [COL_IDX_BITS-1:0] col_mask;
  logic [COL_IDX_BITS-1:0] beat_col;
  logic                    mode_ok;
  logic                    new_err;
  logic [2:0]              new_code;

  assign cmd      = (!cs_n && cke) ? {ras_n, cas_n, we_n} : C_NOP;
  assign col_mask = bbl8_q ? COL_IDX_BITS'(7) : COL_IDX_BITS'(3);
  assign beat_col = (start_q & ~col_mask) | ((start_q + COL_IDX_BITS'(beat_q)) & col_mask);
  assign mem_idx  = {bank_q, beat_col};
  assign mode_ok  = (addr[6:4] == 3'd3 || addr[6:4] == 3'd4 || addr[6:4] == 3'd5)
                    && (addr[2:1] == 2'b01);

  // Byte merge for masked writes; bytes with dm=1 keep their stored value.
  always_comb begin
    mem_wdata = mem_q[mem_idx];
    for (int b = 0; b < DM_BITS; b++) begin
      if (!dm[b]) mem_wdata[b*BYTE_W +: BYTE_W] = dq_in[b*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cl_d     = cl_q;
    bl8_d    = bl8_q;
    open_d   = open_q;
    row_d    = row_q;
    busy_d   = busy_q;
    rd_d     = rd_q;
    bbl8_d   = bbl8_q;
    wait_d   = wait_q;
    beat_d   = beat_q;
    bank_d   = bank_q;
    start_d  = start_q;
    err_d    = err_q;
    code_d   = code_q;
    dq_oe_d  = 1'b0;
    dq_out_d = '0;
    mem_we   = 1'b0;
    new_err  = 1'b0;
    new_code = 3'd0;

    // Burst engine: count down the latency, then one beat per edge.
    if (busy_q) begin
      if (wait_q != 3'd0) begin
        wait_d = wait_q - 3'd1;
      end else begin
        if (rd_q) begin
          dq_oe_d  = 1'b1;
          dq_out_d = mem_q[mem_idx];
        end else begin
          mem_we = 1'b1;
        end
        beat_d = beat_q + 3'd1;
        if (beat_q == (bbl8_q ? 3'd7 : 3'd3)) busy_d = 1'b0;
      end
    end

    if (state_q == PWRUP && cke) state_d = WAIT_PREA;

    case (cmd)
      C_MRS: begin
        if (ba == '0) begin
          if (mode_ok) begin
            cl_d  = addr[6:4];
            bl8_d = addr[0];
          end else begin
            new_err  = 1'b1;
            new_code = E_BAD_MODE;
          end
          if (state_q == WAIT_MRS) state_d = READY;
        end
      end
      C_PRE: begin
        if (addr[10]) open_d = '0;
        else          open_d[ba] = 1'b0;
        if (state_q == WAIT_PREA && addr[10]) state_d = WAIT_MRS;
      end
      C_REF, C_ACT, C_WR, C_RD: begin
        if (state_q != READY) begin
          new_err  = 1'b1;
          new_code = E_NOT_INIT;
        end else if (cmd == C_REF) begin
          if (|open_q) begin
            new_err  = 1'b1;
            new_code = E_REF_OPEN;
          end
        end else if (cmd == C_ACT) begin
          if (open_q[ba]) begin
            new_err  = 1'b1;
            new_code = E_ACT_OPEN;
          end else begin
            open_d[ba] = 1'b1;
            row_d[ba]  = addr;
          end
        end else if (!open_q[ba]) begin
          new_err  = 1'b1;
          new_code = E_CLOSED;
        end else if (busy_q) begin
          new_err  = 1'b1;
          new_code = E_OVERLAP;
        end else begin
          // Reads land CL edges later, writes sample one edge earlier (CL-1).
          busy_d  = 1'b1;
          rd_d    = (cmd == C_RD);
          wait_d  = (cmd == C_RD) ? cl_q - 3'd1 : cl_q - 3'd2;
          beat_d  = 3'd0;
          bank_d  = ba;
          start_d = addr[COL_IDX_BITS-1:0];
          bbl8_d  = bl8_q;
        end
      end
      default: ;
    endcase

    if (new_err && !err_q) begin
      err_d  = 1'b1;
      code_d = new_code;
    end
    ready_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PWRUP;
      ready_q  <= 1'b0;
      cl_q     <= 3'd3;
      bl8_q    <= 1'b0;
      open_q   <= '0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      bbl8_q   <= 1'b0;
      wait_q   <= 3'd0;
      beat_q   <= 3'd0;
      bank_q   <= '0;
      start_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cl_q     <= cl_d;
      bl8_q    <= bl8_d;
      open_q   <= open_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      bbl8_q   <= bbl8_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      bank_q   <= bank_d;
      start_q  <= start_d;
      err_q    <= err_d;
      code_q   <= code_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  // Storage and row registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    row_q <= row_d;
    if (mem_we && !rst) mem_q[mem_idx] <= mem_wdata;
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_ddr2_cmd_responder.sv
// tb/tb_ddr2_cmd_responder.sv - directed vector table plus multi-cycle sequences for ddr2_cmd_responder
module tb_ddr2_cmd_responder;
  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [12:0] addr;
  logic [15:0] dq_in;
  logic [1:0]  dm;
  logic [15:0] dq_out;
  logic        dq_oe, ready, err;
  logic [2:0]  err_code;

  int total = 0;
  int bad   = 0;
  int cl_m  = 3;
  int bl_m  = 4;

  typedef logic [15:0] word8_t [8];
  typedef logic [1:0]  mask8_t [8];

  typedef struct {
    logic        rst;
    logic        cke;
    logic        cs_n;
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq;
    logic [1:0]  dm;
    logic        e_ready;
    logic        e_err;
    logic [2:0]  e_code;
    logic        e_oe;
    logic [15:0] e_dq;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ddr2_cmd_responder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .dq_in(dq_in), .dm(dm), .dq_out(dq_out),
    .dq_oe(dq_oe), .ready(ready), .err(err), .err_code(err_code)
  );

  function automatic vec_t mk(logic r, logic k, logic cs, logic [2:0] c, logic [2:0] b,
                              logic [12:0] a, logic [15:0] d, logic [1:0] m, logic erdy,
                              logic eerr, logic [2:0] ecode, logic eoe, logic [15:0] edq);
    vec_t v;
    v.rst = r; v.cke = k; v.cs_n = cs; v.cmd = c; v.ba = b; v.addr = a; v.dq = d; v.dm = m;
    v.e_ready = erdy; v.e_err = eerr; v.e_code = ecode; v.e_oe = eoe; v.e_dq = edq;
    return v;
  endfunction

  function automatic logic [21:0] outs();
    return {ready, err, err_code, dq_oe, dq_out};
  endfunction

  function automatic logic [21:0] exp_o(logic r, logic e, logic [2:0] c, logic oe, logic [15:0] d);
    return {r, e, c, oe, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a;
  endtask

  task automatic nop();
    cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP; ba = '0; addr = '0;
  endtask

  task automatic do_init(input logic [12:0] mode, input int cl, input int bl);
    rst = 1'b1; cke = 1'b0; dq_in = '0; dm = '0; nop();
    step();
    chk("reset_state", outs(), '0);
    rst = 1'b0; cke = 1'b1;
    step();
    issue(C_PRE, 3'd0, 13'h400); step();
    issue(C_MRS, 3'd0, mode);    step();
    nop();
    chk("init_ready", outs(), exp_o(1'b1, 1'b0, 3'd0, 1'b0, 16'h0));
    cl_m = cl; bl_m = bl;
  endtask

  task automatic do_wr(input logic [2:0] b, input logic [12:0] col, input word8_t d, input mask8_t m);
    issue(C_WR, b, col); step(); nop();
    repeat (cl_m - 2) step();
    for (int i = 0; i < bl_m; i++) begin
      dq_in = d[i]; dm = m[i];
      step();
    end
    dq_in = '0; dm = '0;
  endtask

  task automatic do_rd(input string name, input logic [2:0] b, input logic [12:0] col, input word8_t e);
    issue(C_RD, b, col); step(); nop();
    for (int k = 1; k < cl_m; k++) begin
      step();
      chk($sformatf("%s_lat%0d", name, k), {31'b0, dq_oe}, 32'd0);
    end
    for (int i = 0; i < bl_m; i++) begin
      step();
      chk($sformatf("%s_beat%0d", name, i), {15'b0, dq_oe, dq_out}, {15'b0, 1'b1, e[i]});
    end
    step();
    chk($sformatf("%s_end", name), {31'b0, dq_oe}, 32'd0);
  endtask

  localparam logic [15:0] DA = 16'hAA01, DB = 16'hBB02, DC = 16'hCC03, DD = 16'hDD04;

  initial begin
    word8_t d, e, g, h;
    mask8_t m0, m1;
    rst = 1'b1; cke = 1'b0; dq_in = '0; dm = '0; nop();
    for (int i = 0; i < 8; i++) begin
      m0[i] = 2'b00;
      g[i]  = 16'h3C00 | 16'(i);
      h[i]  = 16'h7100 + 16'(i * 3);
    end

    // rst cke cs cmd ba addr dq dm | ready err code oe dq
    vecs.push_back(mk(1, 0, 1, C_NOP, 0, 13'h000, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, C_ACT, 0, 13'h000, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_ACT, 0, 13'h000, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 3'b110, 0, 13'h000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_PRE, 0, 13'h000, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_MRS, 0, 13'h032, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_PRE, 0, 13'h400, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_MRS, 1, 13'h032, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_MRS, 0, 13'h032, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_ACT, 2, 13'h005, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_WR,  2, 13'h006, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, DA, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, DB, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, DC, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, DD, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, C_RD,  2, 13'h006, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 1, DA));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 1, DB));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 1, DC));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 1, DD));
    vecs.push_back(mk(0, 1, 1, C_NOP, 0, 13'h000, 0,  0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; cke = vecs[i].cke; cs_n = vecs[i].cs_n;
      {ras_n, cas_n, we_n} = vecs[i].cmd; ba = vecs[i].ba; addr = vecs[i].addr;
      dq_in = vecs[i].dq; dm = vecs[i].dm;
      step();
      chk($sformatf("vec%0d", i), outs(),
          exp_o(vecs[i].e_ready, vecs[i].e_err, vecs[i].e_code, vecs[i].e_oe, vecs[i].e_dq));
    end
    nop(); dq_in = '0; dm = '0;

    // Wrap within the 4-beat block.
    d = '{DA, DB, DC, DD, 0, 0, 0, 0};
    do_wr(3'd2, 13'h004, d, m0);
    e = '{DC, DD, DA, DB, 0, 0, 0, 0};
    do_rd("wrap", 3'd2, 13'h006, e);

    // Byte mask: beat 1 keeps its low byte.
    d = '{16'h1122, 16'h5566, 16'h3344, 16'h7788, 0, 0, 0, 0};
    do_wr(3'd2, 13'h000, d, m0);
    m1 = m0; m1[1] = 2'b01;
    d = '{16'h9901, 16'h99AA, 16'h9903, 16'h9904, 0, 0, 0, 0};
    do_wr(3'd2, 13'h000, d, m1);
    e = '{16'h9901, 16'h9966, 16'h9903, 16'h9904, 0, 0, 0, 0};
    do_rd("mask", 3'd2, 13'h000, e);
    chk("no_err_yet", {31'b0, err}, 32'd0);

    // CL=5, BL=8, wrap inside the 8-beat block.
    issue(C_MRS, 3'd0, 13'h053); step(); nop();
    cl_m = 5; bl_m = 8;
    do_wr(3'd2, 13'h000, g, m0);
    for (int i = 0; i < 8; i++) e[i] = g[(3 + i) % 8];
    do_rd("bl8", 3'd2, 13'h003, e);

    // Illegal mode: error and prior mode retained.
    issue(C_MRS, 3'd0, 13'h062); step(); nop();
    chk("bad_mode", outs(), exp_o(1'b1, 1'b1, 3'd2, 1'b0, 16'h0));
    do_rd("keep_mode", 3'd2, 13'h000, g);
    issue(C_MRS, 3'd0, 13'h034); step(); nop();
    chk("bad_mode_sticky", {29'b0, err_code}, 32'd2);

    // Overlapping read is rejected; first burst unaffected.
    do_init(13'h032, 3, 4);
    issue(C_ACT, 3'd1, 13'h000); step();
    do_wr(3'd1, 13'h000, h, m0);
    issue(C_RD, 3'd1, 13'h000); step();
    issue(C_RD, 3'd1, 13'h002); step(); nop();
    chk("overlap_err", outs(), exp_o(1'b1, 1'b1, 3'd6, 1'b0, 16'h0));
    step();
    chk("overlap_lat", {31'b0, dq_oe}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("overlap_beat%0d", i), outs(), exp_o(1'b1, 1'b1, 3'd6, 1'b1, h[i]));
    end
    step();
    chk("overlap_end", {31'b0, dq_oe}, 32'd0);

    // Reset in the middle of a read burst.
    do_init(13'h032, 3, 4);
    issue(C_ACT, 3'd2, 13'h007); step();
    issue(C_RD, 3'd2, 13'h000); step(); nop();
    step(); step(); step();
    chk("mid_beat0", outs(), exp_o(1'b1, 1'b0, 3'd0, 1'b1, g[0]));
    step();
    chk("mid_beat1", outs(), exp_o(1'b1, 1'b0, 3'd0, 1'b1, g[1]));
    rst = 1'b1;
    step();
    chk("mid_rst", outs(), '0);
    step();
    chk("mid_rst_hold", outs(), '0);
    rst = 1'b0;
    step();
    issue(C_PRE, 3'd0, 13'h400); step();
    issue(C_MRS, 3'd0, 13'h032); step();
    issue(C_ACT, 3'd2, 13'h007); step(); nop();
    chk("reinit", outs(), exp_o(1'b1, 1'b0, 3'd0, 1'b0, 16'h0));
    do_rd("persist", 3'd2, 13'h000, g);

    // First error cause is held.
    rst = 1'b1; cke = 1'b1; nop(); step();
    rst = 1'b0; step();
    issue(C_PRE, 3'd0, 13'h400); step();
    issue(C_RD, 3'd0, 13'h000); step();
    chk("not_init", outs(), exp_o(1'b0, 1'b1, 3'd1, 1'b0, 16'h0));
    issue(C_ACT, 3'd0, 13'h000); step(); step();
    issue(C_MRS, 3'd0, 13'h032); step();
    issue(C_ACT, 3'd0, 13'h000); step(); step(); nop();
    chk("first_cause", outs(), exp_o(1'b1, 1'b1, 3'd1, 1'b0, 16'h0));

    do_init(13'h032, 3, 4);
    issue(C_RD, 3'd3, 13'h000); step(); nop();
    chk("closed", outs(), exp_o(1'b1, 1'b1, 3'd5, 1'b0, 16'h0));

    do_init(13'h032, 3, 4);
    issue(C_ACT, 3'd0, 13'h001); step();
    issue(C_REF, 3'd0, 13'h000); step(); nop();
    chk("ref_open", outs(), exp_o(1'b1, 1'b1, 3'd4, 1'b0, 16'h0));

    do_init(13'h032, 3, 4);
    issue(C_ACT, 3'd0, 13'h001); step();
    issue(C_ACT, 3'd0, 13'h002); step(); nop();
    chk("act_open", outs(), exp_o(1'b1, 1'b1, 3'd3, 1'b0, 16'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr2_cmd_responder.md
DDR2_CMD_RESPONDER -- requirements
Module: ddr2_cmd_responder

Interface
REQ-001 Parameters: BA_BITS, default 3, bank address width; ADDR_BITS, default 13, row/column address width; DQ_BITS, default 16, data width; DM_BITS, default 2, data-mask width (one bit per byte); COL_IDX_BITS, default 4, stored columns per bank.
REQ-002 Ports: clk, input, 1, clock; all ports are sampled and driven on its rising edge.
REQ-003 Ports: rst, input, 1, synchronous active-high reset.
REQ-004 Ports: cke, input, 1, DRAM clock enable.
REQ-005 Ports: cs_n, ras_n, cas_n, we_n, inputs, 1 each, DRAM command strobes.
REQ-006 Ports: ba, input, BA_BITS, bank address; addr, input, ADDR_BITS, row/column/mode value.
REQ-007 Ports: dq_in, input, DQ_BITS, write data; dm, input, DM_BITS, byte mask (1 = do not write that byte).
REQ-008 Ports: dq_out, output, DQ_BITS, read data; dq_oe, output, 1, read-data valid/drive enable.
REQ-009 Ports: ready, output, 1, initialisation complete; err, output, 1, sticky protocol error; err_code, output, 3, first error cause.

Function
REQ-010 Each rising edge shall decode one command from {ras_n,cas_n,we_n} when cs_n=0 and cke=1: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 111 NOP.
REQ-011 cs_n=1, cke=0, or encoding 110 shall be treated as NOP.
REQ-012 The init FSM shall have states PWRUP, WAIT_PREA, WAIT_MRS, and READY.
REQ-013 PWRUP shall go to WAIT_PREA on the first edge with cke=1.
REQ-014 WAIT_PREA shall go to WAIT_MRS on PRE with addr[10]=1.
REQ-015 WAIT_MRS shall go to READY on MRS with ba=0; ready=1 in READY.
REQ-016 Before READY, any command other than NOP, PRE, or MRS shall set error code 1 (NOT_INIT) and be ignored.
REQ-017 MRS shall capture CL=addr[6:4] (legal 3,4,5) and BL from addr[2:0] (010 gives 4, 011 gives 8); an illegal value shall set code 2 (BAD_MODE) and leave the prior mode unchanged.
REQ-018 MRS with ba!=0 shall be ignored without error (extended mode registers).
REQ-019 Each bank shall track an open flag and its row.
REQ-020 ACT shall open bank ba with row=addr; ACT to an open bank shall set code 3 (ACT_OPEN) and be ignored.
REQ-021 PRE with addr[10]=1 shall close all banks; with addr[10]=0 it shall close bank ba; PRE to a closed bank is legal.
REQ-022 REF with any bank open shall set code 4 (REF_OPEN).
REQ-023 RD or WR to a closed bank shall set code 5 (CLOSED) and be ignored.
REQ-024 Storage shall be 2^(BA_BITS+COL_IDX_BITS) words indexed by {ba, column}, with column = addr[COL_IDX_BITS-1:0]; rows alias.
REQ-025 Bursts shall be sequential and wrap within the BL-aligned block: beat i uses column (start & ~(BL-1)) | ((start + i) & (BL-1)).
REQ-026 RD accepted at edge T shall drive beat i on dq_out with dq_oe=1 on edge T+CL+i, for i = 0..BL-1; at all other times dq_oe=0 and dq_out=0.
REQ-027 WR accepted at edge T shall sample dq_in/dm on edge T+CL-1+i, for i = 0..BL-1, writing only unmasked bytes.
REQ-028 A RD or WR issued while a burst is pending or active shall set code 6 (OVERLAP) and be ignored; the pending burst shall continue unaffected.
REQ-029 PRE or ACT during an active burst shall be applied to bank state without aborting the burst.
REQ-030 err shall be sticky once set; err_code shall hold the first cause only; later errors shall not change it.
REQ-031 The read path shall be read-before-write: a same-cycle read and write to the same word shall return the old data.

Reset
REQ-032 rst=1 shall force state PWRUP, ready=0, err=0, err_code=0, dq_oe=0, dq_out=0, all banks closed, CL=3, and BL=4.
REQ-033 rst shall cancel any pending or active burst immediately; storage contents are not reset.
REQ-034 Reset shall take priority over any command presented on the same edge.

Verification
REQ-035 Init: cke 0 then 1, PRE addr[10]=1, MRS ba=0 addr=0x032 -> ready=1, CL=3, BL=4, err=0.
REQ-036 Write/read: ACT b2 row 5; WR b2 col 0x6 with data A..D; RD b2 col 0x6 at T -> dq_oe on T+3..T+6 with A,B,C,D.
REQ-037 Wrap: BL=4 burst data stored at cols 4..7 as A,B,C,D; RD col 0x6 -> beats at cols 6,7,4,5 (C,D,A,B).
REQ-038 Mask: WR with dm=01 on beat 1 -> readback beat 1 low byte unchanged, high byte updated.
REQ-039 Errors: RD before MRS -> err=1, code 1; then ACT twice to b0 -> err_code stays 1.
REQ-040 Reset mid-read: rst asserted on T+4 of a CL=3 read -> dq_oe=0 from the next edge, ready=0, banks closed.
